// File: rtl/usb_bulk_pkg.sv
// Shared types and helpers for the bulk endpoint router.
package usb_bulk_pkg;

  localparam int EP_W   = 4;
  localparam int MAX_CH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IN_XFER  = 3'd1,
    ST_OUT_XFER = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_WAIT_END = 3'd4
  } state_e;

  function automatic logic ep_in_range(
    input logic [EP_W-1:0] ep,
    input int              first,
    input int              num
  );
    return (int'(ep) >= first) && (int'(ep) < first + num);
  endfunction

endpackage

// File: rtl/usb_ep_decode.sv
// Maps an endpoint number onto a contiguous channel range.
module usb_ep_decode
  import usb_bulk_pkg::*;
#(
  parameter int FIRST = 1,
  parameter int NUM   = 1
) (
  input  logic [EP_W-1:0] ep_i,
  output logic            valid_o,
  output logic [EP_W-1:0] idx_o
);

  localparam logic [EP_W-1:0] FIRST_EP = EP_W'(FIRST);

  assign valid_o = ep_in_range(ep_i, FIRST, NUM);
  assign idx_o   = valid_o ? ep_i - FIRST_EP : '0;

endmodule

// File: rtl/usb_bulk_ep_router.sv
// Routes the transactor bulk port to NUM_IN IN and NUM_OUT OUT channels.
// Endpoint halt support is built when USB_BULK_HALT_EN is defined.
module usb_bulk_ep_router
  import usb_bulk_pkg::*;
#(
  parameter int NUM_IN    = 2,
  parameter int IN_FIRST  = 2,
  parameter int NUM_OUT   = 1,
  parameter int OUT_FIRST = 1
) (
  input  logic                        clock,
  input  logic                        reset,
`ifdef USB_BULK_HALT_EN
  input  logic                        halt_set_i,
  input  logic                        halt_clr_i,
  input  logic [7:0]                  halt_addr_i,
  output logic [NUM_IN+NUM_OUT-1:0]   halted_o,
`endif
  input  logic [3:0]                  tok_endp_i,
  output logic                        blk_in_ready_o,
  output logic                        blk_out_ready_o,
  input  logic                        blk_start_i,
  input  logic                        blk_cycle_i,
  input  logic                        blk_fetch_i,
  input  logic                        blk_store_i,
  input  logic [3:0]                  blk_endpt_i,
  output logic                        blk_error_o,
  input  logic [NUM_IN-1:0]           in_ready_i,
  input  logic [NUM_OUT-1:0]          out_space_i,
  output logic [NUM_IN+NUM_OUT-1:0]   ch_start_o,
  output logic [NUM_IN+NUM_OUT-1:0]   ch_cycle_o,
  input  logic [NUM_IN-1:0]           blki_tvalid_i,
  output logic [NUM_IN-1:0]           blki_tready_o,
  input  logic [NUM_IN-1:0]           blki_tlast_i,
  input  logic [NUM_IN-1:0]           blki_tkeep_i,
  input  logic [NUM_IN*8-1:0]         blki_tdata_i,
  output logic                        usbi_tvalid_o,
  input  logic                        usbi_tready_i,
  output logic                        usbi_tlast_o,
  output logic                        usbi_tkeep_o,
  output logic [7:0]                  usbi_tdata_o,
  input  logic                        usbo_tvalid_i,
  output logic                        usbo_tready_o,
  input  logic                        usbo_tlast_i,
  input  logic                        usbo_tkeep_i,
  input  logic [7:0]                  usbo_tdata_i,
  output logic [NUM_OUT-1:0]          blko_tvalid_o,
  input  logic [NUM_OUT-1:0]          blko_tready_i,
  output logic [NUM_OUT-1:0]          blko_tlast_o,
  output logic [NUM_OUT-1:0]          blko_tkeep_o,
  output logic [NUM_OUT*8-1:0]        blko_tdata_o
);

  localparam int NCH = NUM_IN + NUM_OUT;
  typedef logic [NCH-1:0] chv_t;

  if (NUM_IN < 1 || NUM_IN > 15 || IN_FIRST < 0 ||
      IN_FIRST + NUM_IN - 1 > 15) begin : g_bad_in
    $error("IN endpoint range exceeds 0..15");
  end
  if (NUM_OUT < 1 || NUM_OUT > 15 || OUT_FIRST < 0 ||
      OUT_FIRST + NUM_OUT - 1 > 15) begin : g_bad_out
    $error("OUT endpoint range exceeds 0..15");
  end

  chv_t halted;

  // Channel vectors padded to 16 so a 4-bit index is always in range.
  logic [MAX_CH-1:0] in_rdy_pad;
  logic [MAX_CH-1:0] out_spc_pad;
  logic [MAX_CH-1:0] in_halt_pad;
  logic [MAX_CH-1:0] out_halt_pad;
  logic [MAX_CH-1:0] iv_pad;
  logic [MAX_CH-1:0] il_pad;
  logic [MAX_CH-1:0] ik_pad;
  logic [MAX_CH-1:0] ot_pad;
  logic [7:0]        id_pad [MAX_CH];

  always_comb begin
    in_rdy_pad   = '0;
    out_spc_pad  = '0;
    in_halt_pad  = '0;
    out_halt_pad = '0;
    iv_pad       = '0;
    il_pad       = '0;
    ik_pad       = '0;
    ot_pad       = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      id_pad[k] = '0;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      in_rdy_pad[k]  = in_ready_i[k];
      in_halt_pad[k] = halted[k];
      iv_pad[k]      = blki_tvalid_i[k];
      il_pad[k]      = blki_tlast_i[k];
      ik_pad[k]      = blki_tkeep_i[k];
      id_pad[k]      = blki_tdata_i[8*k +: 8];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      out_spc_pad[k]  = out_space_i[k];
      out_halt_pad[k] = halted[NUM_IN+k];
      ot_pad[k]       = blko_tready_i[k];
    end
  end

  logic            tiv, tov, siv, sov;
  logic [EP_W-1:0] tii, toi, sii, soi;

  usb_ep_decode #(.FIRST(IN_FIRST), .NUM(NUM_IN)) u_tok_in (
    .ep_i    (tok_endp_i),
    .valid_o (tiv),
    .idx_o   (tii)
  );

  usb_ep_decode #(.FIRST(OUT_FIRST), .NUM(NUM_OUT)) u_tok_out (
    .ep_i    (tok_endp_i),
    .valid_o (tov),
    .idx_o   (toi)
  );

  usb_ep_decode #(.FIRST(IN_FIRST), .NUM(NUM_IN)) u_xfer_in (
    .ep_i    (blk_endpt_i),
    .valid_o (siv),
    .idx_o   (sii)
  );

  usb_ep_decode #(.FIRST(OUT_FIRST), .NUM(NUM_OUT)) u_xfer_out (
    .ep_i    (blk_endpt_i),
    .valid_o (sov),
    .idx_o   (soi)
  );

  logic in_rdy_q, in_rdy_d;
  logic out_rdy_q, out_rdy_d;

  assign in_rdy_d  = tiv && in_rdy_pad[tii] && !in_halt_pad[tii];
  assign out_rdy_d = tov && out_spc_pad[toi] && !out_halt_pad[toi];

  always_ff @(posedge clock) begin
    if (reset) begin
      in_rdy_q  <= 1'b0;
      out_rdy_q <= 1'b0;
    end else begin
      in_rdy_q  <= in_rdy_d;
      out_rdy_q <= out_rdy_d;
    end
  end

  assign blk_in_ready_o  = in_rdy_q;
  assign blk_out_ready_o = out_rdy_q;

  state_e          state_q;
  logic [EP_W-1:0] idx_q;
  chv_t            ch_start_q;
  chv_t            ch_cycle_q;
  logic            err_q;

  logic in_act, out_act, drn_act;
  logic in_ok, out_ok;
  logic in_last_hs, out_last_hs;

  assign in_act  = (state_q == ST_IN_XFER);
  assign out_act = (state_q == ST_OUT_XFER);
  assign drn_act = (state_q == ST_DRAIN);

  assign in_ok  = siv && !in_halt_pad[sii];
  assign out_ok = sov && !out_halt_pad[soi];

  assign in_last_hs  = usbi_tvalid_o && usbi_tready_i && usbi_tlast_o;
  assign out_last_hs = usbo_tvalid_i && usbo_tready_o && usbo_tlast_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ch_start_q <= '0;
      ch_cycle_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ch_start_q <= '0;
      err_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (blk_start_i) begin
            if (blk_fetch_i && !blk_store_i && in_ok) begin
              state_q    <= ST_IN_XFER;
              idx_q      <= sii;
              ch_start_q <= chv_t'(1) << sii;
              ch_cycle_q <= chv_t'(1) << sii;
            end else if (blk_store_i && !blk_fetch_i && out_ok) begin
              state_q    <= ST_OUT_XFER;
              idx_q      <= soi;
              ch_start_q <= chv_t'(1) << (NUM_IN + int'(soi));
              ch_cycle_q <= chv_t'(1) << (NUM_IN + int'(soi));
            end else begin
              err_q      <= 1'b1;
              ch_cycle_q <= '0;
              state_q    <= blk_store_i ? ST_DRAIN : ST_WAIT_END;
            end
          end
        end
        ST_IN_XFER: begin
          if (!blk_cycle_i) begin
            state_q    <= ST_IDLE;
            ch_cycle_q <= '0;
          end else if (in_last_hs) begin
            state_q <= ST_WAIT_END;
          end
        end
        ST_OUT_XFER, ST_DRAIN: begin
          if (!blk_cycle_i) begin
            state_q    <= ST_IDLE;
            ch_cycle_q <= '0;
          end else if (out_last_hs) begin
            state_q <= ST_WAIT_END;
          end
        end
        ST_WAIT_END: begin
          if (!blk_cycle_i) begin
            state_q    <= ST_IDLE;
            ch_cycle_q <= '0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ch_cycle_q <= '0;
        end
      endcase
    end
  end

  assign ch_start_o  = ch_start_q;
  assign ch_cycle_o  = ch_cycle_q;
  assign blk_error_o = err_q;

  assign usbi_tvalid_o = in_act && iv_pad[idx_q];
  assign usbi_tlast_o  = in_act && il_pad[idx_q];
  assign usbi_tkeep_o  = in_act && ik_pad[idx_q];
  assign usbi_tdata_o  = in_act ? id_pad[idx_q] : '0;

  always_comb begin
    blki_tready_o = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      blki_tready_o[k] = in_act && (idx_q == EP_W'(k)) && usbi_tready_i;
    end
  end

  always_comb begin
    blko_tvalid_o = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      blko_tvalid_o[k] = out_act && (idx_q == EP_W'(k)) && usbo_tvalid_i;
    end
  end

  // Data fans out to every OUT channel; only the selected one sees tvalid.
  assign blko_tdata_o  = out_act ? {NUM_OUT{usbo_tdata_i}} : '0;
  assign blko_tlast_o  = {NUM_OUT{out_act && usbo_tlast_i}};
  assign blko_tkeep_o  = {NUM_OUT{out_act && usbo_tkeep_i}};
  assign usbo_tready_o = (out_act && ot_pad[idx_q]) || drn_act;

`ifdef USB_BULK_HALT_EN
  logic            hiv, hov;
  logic [EP_W-1:0] hii, hoi;
  logic            h_hit;
  chv_t            hmask;
  chv_t            halted_q, halted_d;

  usb_ep_decode #(.FIRST(IN_FIRST), .NUM(NUM_IN)) u_halt_in (
    .ep_i    (halt_addr_i[3:0]),
    .valid_o (hiv),
    .idx_o   (hii)
  );

  usb_ep_decode #(.FIRST(OUT_FIRST), .NUM(NUM_OUT)) u_halt_out (
    .ep_i    (halt_addr_i[3:0]),
    .valid_o (hov),
    .idx_o   (hoi)
  );

  assign h_hit = (halt_addr_i[6:4] == 3'b000);

  // Clear is applied after set so it wins when both strobe together.
  always_comb begin
    hmask = '0;
    if (h_hit && halt_addr_i[7] && hiv) begin
      hmask = chv_t'(1) << hii;
    end else if (h_hit && !halt_addr_i[7] && hov) begin
      hmask = chv_t'(1) << (NUM_IN + int'(hoi));
    end
    halted_d = halted_q;
    if (halt_set_i) begin
      halted_d = halted_d | hmask;
    end
    if (halt_clr_i) begin
      halted_d = halted_d & ~hmask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      halted_q <= '0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted   = halted_q;
  assign halted_o = halted_q;
`else
  assign halted = '0;
`endif

endmodule

// File: tb/tb_usb_bulk_ep_router.sv
// Scoreboard bench for usb_bulk_ep_router (NUM_IN=2 @EP2, NUM_OUT=1 @EP1).
module tb_usb_bulk_ep_router;

  localparam int NIN  = 2;
  localparam int NOUT = 1;
  localparam int NCH  = NIN + NOUT;

  logic              clock = 1'b0;
  logic              reset;
`ifdef USB_BULK_HALT_EN
  logic              halt_set_i, halt_clr_i;
  logic [7:0]        halt_addr_i;
  logic [NCH-1:0]    halted_o;
`endif
  logic [3:0]        tok_endp_i;
  logic              blk_in_ready_o, blk_out_ready_o;
  logic              blk_start_i, blk_cycle_i, blk_fetch_i, blk_store_i;
  logic [3:0]        blk_endpt_i;
  logic              blk_error_o;
  logic [NIN-1:0]    in_ready_i;
  logic [NOUT-1:0]   out_space_i;
  logic [NCH-1:0]    ch_start_o, ch_cycle_o;
  logic [NIN-1:0]    blki_tvalid_i, blki_tready_o, blki_tlast_i, blki_tkeep_i;
  logic [NIN*8-1:0]  blki_tdata_i;
  logic              usbi_tvalid_o, usbi_tready_i, usbi_tlast_o, usbi_tkeep_o;
  logic [7:0]        usbi_tdata_o;
  logic              usbo_tvalid_i, usbo_tready_o, usbo_tlast_i, usbo_tkeep_i;
  logic [7:0]        usbo_tdata_i;
  logic [NOUT-1:0]   blko_tvalid_o, blko_tready_i, blko_tlast_o, blko_tkeep_o;
  logic [NOUT*8-1:0] blko_tdata_o;

  usb_bulk_ep_router #(
    .NUM_IN(NIN), .IN_FIRST(2), .NUM_OUT(NOUT), .OUT_FIRST(1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
`ifdef USB_BULK_HALT_EN
    .halt_set_i      (halt_set_i),
    .halt_clr_i      (halt_clr_i),
    .halt_addr_i     (halt_addr_i),
    .halted_o        (halted_o),
`endif
    .tok_endp_i      (tok_endp_i),
    .blk_in_ready_o  (blk_in_ready_o),
    .blk_out_ready_o (blk_out_ready_o),
    .blk_start_i     (blk_start_i),
    .blk_cycle_i     (blk_cycle_i),
    .blk_fetch_i     (blk_fetch_i),
    .blk_store_i     (blk_store_i),
    .blk_endpt_i     (blk_endpt_i),
    .blk_error_o     (blk_error_o),
    .in_ready_i      (in_ready_i),
    .out_space_i     (out_space_i),
    .ch_start_o      (ch_start_o),
    .ch_cycle_o      (ch_cycle_o),
    .blki_tvalid_i   (blki_tvalid_i),
    .blki_tready_o   (blki_tready_o),
    .blki_tlast_i    (blki_tlast_i),
    .blki_tkeep_i    (blki_tkeep_i),
    .blki_tdata_i    (blki_tdata_i),
    .usbi_tvalid_o   (usbi_tvalid_o),
    .usbi_tready_i   (usbi_tready_i),
    .usbi_tlast_o    (usbi_tlast_o),
    .usbi_tkeep_o    (usbi_tkeep_o),
    .usbi_tdata_o    (usbi_tdata_o),
    .usbo_tvalid_i   (usbo_tvalid_i),
    .usbo_tready_o   (usbo_tready_o),
    .usbo_tlast_i    (usbo_tlast_i),
    .usbo_tkeep_i    (usbo_tkeep_i),
    .usbo_tdata_i    (usbo_tdata_i),
    .blko_tvalid_o   (blko_tvalid_o),
    .blko_tready_i   (blko_tready_i),
    .blko_tlast_o    (blko_tlast_o),
    .blko_tkeep_o    (blko_tkeep_o),
    .blko_tdata_o    (blko_tdata_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      exp_in[$];
  beat_t      exp_out[$];
  logic [7:0] pay [16];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every handshake on either stream pops one expected beat.
  always @(negedge clock) begin
    beat_t b;
    if (usbi_tvalid_o && usbi_tready_i) begin
      if (exp_in.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL in_unexpected: got %0h expected none", usbi_tdata_o);
      end else begin
        b = exp_in.pop_front();
        chk("in_data", usbi_tdata_o, b.d);
        chk("in_last", usbi_tlast_o, b.l);
      end
    end
    if (blko_tvalid_o[0] && blko_tready_i[0]) begin
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected none", blko_tdata_o);
      end else begin
        b = exp_out.pop_front();
        chk("out_data", blko_tdata_o[7:0], b.d);
        chk("out_last", blko_tlast_o[0], b.l);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) pay[i] = base + 8'(i);
  endtask

  task automatic push_in(input int n, input int last_at);
    for (int i = 0; i < n; i++) exp_in.push_back('{pay[i], i == last_at});
  endtask

  task automatic push_out(input int n);
    for (int i = 0; i < n; i++) exp_out.push_back('{pay[i], i == n - 1});
  endtask

  task automatic start(input logic f, input logic s, input logic [3:0] ep);
    blk_start_i = 1'b1;
    blk_fetch_i = f;
    blk_store_i = s;
    blk_endpt_i = ep;
    blk_cycle_i = 1'b1;
    tick();
    blk_start_i = 1'b0;
  endtask

  task automatic end_cycle();
    blk_cycle_i = 1'b0;
    blk_fetch_i = 1'b0;
    blk_store_i = 1'b0;
    tick();
  endtask

  task automatic probe(input logic [3:0] ep, output logic ir, output logic orr);
    tok_endp_i = ep;
    tick();
    look();
    ir  = blk_in_ready_o;
    orr = blk_out_ready_o;
    tick();
  endtask

  task automatic send_in(input int ch, input int n, input int last_at,
                         input bit tog, output bit quiet);
    int         i = 0;
    int         cyc = 0;
    logic       hs;
    logic [1:0] own;
    own   = 2'b01 << ch;
    quiet = 1'b1;
    while (i < n && cyc < 60) begin
      blki_tvalid_i = 2'b11;
      blki_tkeep_i  = 2'b11;
      blki_tlast_i  = 2'b11;
      blki_tdata_i  = 16'hEEEE;
      blki_tdata_i[8*ch +: 8] = pay[i];
      blki_tlast_i[ch] = (i == last_at);
      usbi_tready_i = tog ? cyc[0] : 1'b1;
      look();
      if ((blki_tready_o & ~own) != 2'b00) quiet = 1'b0;
      hs = blki_tready_o[ch];
      tick();
      if (hs) i++;
      cyc++;
    end
    chk("in_beats", i, n);
    blki_tvalid_i = '0;
    usbi_tready_i = 1'b0;
  endtask

  task automatic send_out(input int n, input bit tog,
                          output bit saw_v, output bit saw_lo);
    int   i = 0;
    int   cyc = 0;
    logic hs;
    saw_v  = 1'b0;
    saw_lo = 1'b0;
    while (i < n && cyc < 60) begin
      usbo_tvalid_i = 1'b1;
      usbo_tkeep_i  = 1'b1;
      usbo_tdata_i  = pay[i];
      usbo_tlast_i  = (i == n - 1);
      blko_tready_i = tog ? 1'((cyc % 3) != 2) : 1'b1;
      look();
      if (blko_tvalid_o != '0) saw_v = 1'b1;
      if (!usbo_tready_o) saw_lo = 1'b1;
      hs = usbo_tready_o;
      tick();
      if (hs) i++;
      cyc++;
    end
    chk("out_beats", i, n);
    usbo_tvalid_i = 1'b0;
    usbo_tlast_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ir, orr;
    bit   q, sv, slo;
`ifdef USB_BULK_HALT_EN
    halt_set_i  = 1'b0;
    halt_clr_i  = 1'b0;
    halt_addr_i = '0;
`endif
    reset = 1'b1;
    tok_endp_i = 4'd2;
    in_ready_i = 2'b11;
    out_space_i = 1'b1;
    blk_start_i = 0; blk_cycle_i = 0; blk_fetch_i = 0; blk_store_i = 0;
    blk_endpt_i = '0;
    blki_tvalid_i = '0; blki_tlast_i = '0; blki_tkeep_i = '0;
    blki_tdata_i = '0;
    usbi_tready_i = 0;
    usbo_tvalid_i = 0; usbo_tlast_i = 0; usbo_tkeep_i = 0; usbo_tdata_i = '0;
    blko_tready_i = '0;
    repeat (3) tick();
    look();
    chk("rst_in_ready", blk_in_ready_o, 0);
    chk("rst_out_ready", blk_out_ready_o, 0);
    chk("rst_error", blk_error_o, 0);
    chk("rst_ch_start", ch_start_o, 0);
    chk("rst_ch_cycle", ch_cycle_o, 0);
    chk("rst_usbo_tready", usbo_tready_o, 0);
    chk("rst_blki_tready", blki_tready_o, 0);
    tick();

    // Readiness decode
    reset = 1'b0;
    tok_endp_i = 4'd3;
    in_ready_i = 2'b10;
    look();
    chk("rdy_latency", blk_in_ready_o, 0);
    tick();
    probe(4'd3, ir, orr);
    chk("rdy_ep3", ir, 1);
    probe(4'd4, ir, orr);
    chk("rdy_ep4_out_of_range", ir, 0);
    probe(4'd2, ir, orr);
    chk("rdy_ep2_empty", ir, 0);
    probe(4'd1, ir, orr);
    chk("rdy_ep1_out", orr, 1);
    chk("rdy_ep1_not_in", ir, 0);
    out_space_i = 1'b0;
    probe(4'd1, ir, orr);
    chk("rdy_ep1_full", orr, 0);
    out_space_i = 1'b1;
    probe(4'd9, ir, orr);
    chk("rdy_ep9_in", ir, 0);
    chk("rdy_ep9_out", orr, 0);

    // IN transfer on EP2, tready toggling
    fill(8'hA1);
    start(1'b1, 1'b0, 4'd2);
    look();
    chk("in_ch_start", ch_start_o, 3'b001);
    chk("in_ch_cycle", ch_cycle_o, 3'b001);
    chk("in_no_error", blk_error_o, 0);
    tick();
    look();
    chk("in_start_once", ch_start_o, 0);
    tick();
    push_in(5, 4);
    send_in(0, 5, 4, 1'b1, q);
    chk("in_ch1_tready_quiet", q, 1);
    blki_tvalid_i = 2'b11;
    usbi_tready_i = 1'b1;
    look();
    chk("in_waitend_valid", usbi_tvalid_o, 0);
    chk("in_waitend_cycle", ch_cycle_o, 3'b001);
    tick();
    blki_tvalid_i = '0;
    usbi_tready_i = 1'b0;
    end_cycle();
    look();
    chk("in_idle_cycle", ch_cycle_o, 0);
    tick();

    // OUT transfer on EP1, 8 bytes
    fill(8'hB0);
    start(1'b0, 1'b1, 4'd1);
    look();
    chk("out_ch_cycle", ch_cycle_o, 3'b100);
    chk("out_no_error", blk_error_o, 0);
    tick();
    push_out(8);
    send_out(8, 1'b1, sv, slo);
    usbo_tvalid_i = 1'b1;
    usbo_tdata_i  = 8'hFF;
    blko_tready_i = 1'b1;
    blk_start_i = 1'b1; blk_fetch_i = 1'b1; blk_store_i = 1'b0;
    blk_endpt_i = 4'd2;
    look();
    chk("out_waitend_tready", usbo_tready_o, 0);
    chk("out_waitend_tvalid", blko_tvalid_o, 0);
    tick();
    blk_start_i = 1'b0;
    look();
    chk("start_ignored_busy", ch_start_o, 0);
    chk("out_waitend_cycle", ch_cycle_o, 3'b100);
    tick();
    usbo_tvalid_i = 1'b0;
    end_cycle();
    look();
    chk("out_idle_cycle", ch_cycle_o, 0);
    tick();

    // Store to unconfigured EP9 is drained
    fill(8'hC0);
    start(1'b0, 1'b1, 4'd9);
    look();
    chk("ep9_error", blk_error_o, 1);
    chk("ep9_ch_cycle", ch_cycle_o, 0);
    tick();
    look();
    chk("ep9_error_once", blk_error_o, 0);
    tick();
    send_out(4, 1'b0, sv, slo);
    chk("drain_no_tvalid", sv, 0);
    chk("drain_tready_high", slo, 0);
    usbo_tvalid_i = 1'b1;
    look();
    chk("drain_waitend_tready", usbo_tready_o, 0);
    tick();
    usbo_tvalid_i = 1'b0;
    end_cycle();

    // fetch+store together errors and drains
    start(1'b1, 1'b1, 4'd2);
    look();
    chk("both_error", blk_error_o, 1);
    chk("both_drain_tready", usbo_tready_o, 1);
    chk("both_no_start", ch_start_o, 0);
    tick();
    end_cycle();
    look();
    chk("both_idle_tready", usbo_tready_o, 0);
    tick();

    // fetch on an OUT-only endpoint errors without draining
    start(1'b1, 1'b0, 4'd1);
    look();
    chk("fetch_ep1_error", blk_error_o, 1);
    chk("fetch_ep1_tready", usbo_tready_o, 0);
    tick();
    end_cycle();

    // Reset in the middle of an IN packet
    fill(8'hD0);
    start(1'b1, 1'b0, 4'd2);
    tick();
    push_in(2, 99);
    send_in(0, 2, 99, 1'b0, q);
    blki_tvalid_i = 2'b01;
    blki_tdata_i[7:0] = pay[2];
    blki_tlast_i = '0;
    usbi_tready_i = 1'b0;
    reset = 1'b1;
    tick();
    usbi_tready_i = 1'b1;
    look();
    chk("midrst_usbi_valid", usbi_tvalid_o, 0);
    chk("midrst_blki_tready", blki_tready_o, 0);
    chk("midrst_ch_cycle", ch_cycle_o, 0);
    chk("midrst_in_ready", blk_in_ready_o, 0);
    tick();
    reset = 1'b0;
    blk_cycle_i = 1'b0;
    blki_tvalid_i = '0;
    usbi_tready_i = 1'b0;
    in_ready_i = 2'b10;
    probe(4'd3, ir, orr);
    chk("post_rst_rdy_ep3", ir, 1);
    fill(8'h50);
    start(1'b1, 1'b0, 4'd3);
    look();
    chk("ep3_ch_start", ch_start_o, 3'b010);
    chk("ep3_ch_cycle", ch_cycle_o, 3'b010);
    tick();
    push_in(3, 2);
    send_in(1, 3, 2, 1'b1, q);
    chk("ep3_ch0_tready_quiet", q, 1);
    end_cycle();
    look();
    chk("ep3_idle_cycle", ch_cycle_o, 0);
    tick();

`ifdef USB_BULK_HALT_EN
    in_ready_i = 2'b01;
    halt_addr_i = 8'h82;
    halt_set_i = 1'b1;
    tick();
    halt_set_i = 1'b0;
    look();
    chk("halt_set", halted_o, 3'b001);
    tick();
    probe(4'd2, ir, orr);
    chk("halt_ready_masked", ir, 0);
    start(1'b1, 1'b0, 4'd2);
    look();
    chk("halt_start_error", blk_error_o, 1);
    chk("halt_no_cycle", ch_cycle_o, 0);
    tick();
    end_cycle();
    halt_set_i = 1'b1;
    halt_clr_i = 1'b1;
    tick();
    halt_set_i = 1'b0;
    halt_clr_i = 1'b0;
    look();
    chk("halt_clr_wins", halted_o, 0);
    tick();
    probe(4'd2, ir, orr);
    chk("halt_ready_back", ir, 1);
`endif

    chk("sb_in_empty", exp_in.size(), 0);
    chk("sb_out_empty", exp_out.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
